// File: rtl/pipeline_hazard_if.sv
// Signal bundle between the pipeline datapath and the hazard controller.
// The master side is the datapath/bench, the slave side is the controller.
interface pipeline_hazard_if #(
    parameter int CNT_W = 32
);
    logic [4:0]       idRs1;
    logic [4:0]       idRs2;
    logic             idUseRs1;
    logic             idUseRs2;
    logic             exMEMRead;
    logic [4:0]       exRegDes;
    logic             exBranchTaken;
    logic             memMEMRead;
    logic             memMEMWrite;
    logic             dmemReady;
    logic             dmemReq;
    logic             pcStall;
    logic             ifidStall;
    logic             ifidFlush;
    logic             idexStall;
    logic             idexFlush;
    logic             exmemStall;
    logic             memwbBubble;
    logic             memTimeout;
    logic [CNT_W-1:0] stallCycles;
    logic [CNT_W-1:0] flushCount;

    modport master (
        output idRs1, idRs2, idUseRs1, idUseRs2, exMEMRead, exRegDes,
               exBranchTaken, memMEMRead, memMEMWrite, dmemReady,
        input  dmemReq, pcStall, ifidStall, ifidFlush, idexStall, idexFlush,
               exmemStall, memwbBubble, memTimeout, stallCycles, flushCount
    );

    modport slave (
        input  idRs1, idRs2, idUseRs1, idUseRs2, exMEMRead, exRegDes,
               exBranchTaken, memMEMRead, memMEMWrite, dmemReady,
        output dmemReq, pcStall, ifidStall, ifidFlush, idexStall, idexFlush,
               exmemStall, memwbBubble, memTimeout, stallCycles, flushCount
    );
endinterface

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush controller for a 5-stage RISC-V pipeline: load-use, branch
// redirect and a timed data-memory handshake, plus stall/flush counters.
module pipeline_hazard_ctrl #(
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 32
) (
    input logic              clk,
    input logic              rst,
    pipeline_hazard_if.slave hz
);
    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_WAIT  = 2'd1,
        ST_ABORT = 2'd2
    } state_t;

    localparam logic [7:0]       WAIT_LAST = 8'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0] CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};

    state_t           state_r;
    state_t           state_s;
    logic [7:0]       wait_cnt_r;
    logic [7:0]       wait_cnt_s;
    logic             mem_access_s;
    logic             mem_stall_s;
    logic             dmem_req_s;
    logic             abort_s;
    logic             load_use_s;
    logic             pc_stall_s;
    logic             ifid_stall_s;
    logic             ifid_flush_s;
    logic             idex_stall_s;
    logic             idex_flush_s;
    logic             exmem_stall_s;
    logic             memwb_bubble_s;
    logic             mem_timeout_r;
    logic [CNT_W-1:0] stall_cnt_r;
    logic [CNT_W-1:0] flush_cnt_r;

    assign mem_access_s = hz.memMEMRead | hz.memMEMWrite;

    // x0 is hard-wired zero, so a load targeting it can never create a hazard
    assign load_use_s = hz.exMEMRead && (hz.exRegDes != 5'd0) &&
                        ((hz.idUseRs1 && (hz.idRs1 == hz.exRegDes)) ||
                         (hz.idUseRs2 && (hz.idRs2 == hz.exRegDes)));

    // Memory-handshake FSM state and wait counter
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r    <= ST_RUN;
            wait_cnt_r <= 8'd0;
        end else begin
            state_r    <= state_s;
            wait_cnt_r <= wait_cnt_s;
        end
    end

    // Memory-handshake FSM next state; the RUN cycle itself counts as the first stall
    always_comb begin
        state_s     = state_r;
        wait_cnt_s  = wait_cnt_r;
        mem_stall_s = 1'b0;
        dmem_req_s  = 1'b0;
        abort_s     = 1'b0;
        case (state_r)
            ST_RUN: begin
                dmem_req_s = mem_access_s;
                if (mem_access_s && !hz.dmemReady) begin
                    mem_stall_s = 1'b1;
                    wait_cnt_s  = 8'd1;
                    state_s     = ST_WAIT;
                end else begin
                    state_s = ST_RUN;
                end
            end
            ST_WAIT: begin
                dmem_req_s = 1'b1;
                if (hz.dmemReady) begin
                    state_s = ST_RUN;
                end else if (wait_cnt_r == WAIT_LAST) begin
                    mem_stall_s = 1'b1;
                    state_s     = ST_ABORT;
                end else begin
                    mem_stall_s = 1'b1;
                    wait_cnt_s  = wait_cnt_r + 8'd1;
                end
            end
            ST_ABORT: begin
                abort_s = 1'b1;
                state_s = ST_RUN;
            end
            default: begin
                state_s    = ST_RUN;
                wait_cnt_s = 8'd0;
            end
        endcase
    end

    // Pipeline controls with priority memory stall > branch > load-use
    always_comb begin
        pc_stall_s     = 1'b0;
        ifid_stall_s   = 1'b0;
        ifid_flush_s   = 1'b0;
        idex_stall_s   = 1'b0;
        idex_flush_s   = 1'b0;
        exmem_stall_s  = 1'b0;
        memwb_bubble_s = 1'b0;
        if (rst) begin
            memwb_bubble_s = 1'b0;
        end else if (mem_stall_s) begin
            pc_stall_s     = 1'b1;
            ifid_stall_s   = 1'b1;
            idex_stall_s   = 1'b1;
            exmem_stall_s  = 1'b1;
            memwb_bubble_s = 1'b1;
        end else begin
            memwb_bubble_s = abort_s;
            if (hz.exBranchTaken) begin
                ifid_flush_s = 1'b1;
                idex_flush_s = 1'b1;
            end else if (load_use_s) begin
                pc_stall_s   = 1'b1;
                ifid_stall_s = 1'b1;
                idex_flush_s = 1'b1;
            end else begin
                idex_flush_s = 1'b0;
            end
        end
    end

    // Sticky timeout flag and saturating performance counters
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_timeout_r <= 1'b0;
            stall_cnt_r   <= {CNT_W{1'b0}};
            flush_cnt_r   <= {CNT_W{1'b0}};
        end else begin
            if (state_r == ST_ABORT) begin
                mem_timeout_r <= 1'b1;
            end else begin
                mem_timeout_r <= mem_timeout_r;
            end
            if (pc_stall_s && (stall_cnt_r != CNT_MAX)) begin
                stall_cnt_r <= stall_cnt_r + CNT_ONE;
            end else begin
                stall_cnt_r <= stall_cnt_r;
            end
            if (ifid_flush_s && (flush_cnt_r != CNT_MAX)) begin
                flush_cnt_r <= flush_cnt_r + CNT_ONE;
            end else begin
                flush_cnt_r <= flush_cnt_r;
            end
        end
    end

    assign hz.dmemReq     = dmem_req_s & ~rst;
    assign hz.pcStall     = pc_stall_s;
    assign hz.ifidStall   = ifid_stall_s;
    assign hz.ifidFlush   = ifid_flush_s;
    assign hz.idexStall   = idex_stall_s;
    assign hz.idexFlush   = idex_flush_s;
    assign hz.exmemStall  = exmem_stall_s;
    assign hz.memwbBubble = memwb_bubble_s;
    assign hz.memTimeout  = mem_timeout_r;
    assign hz.stallCycles = stall_cnt_r;
    assign hz.flushCount  = flush_cnt_r;
endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench for pipeline_hazard_ctrl; control vector order is
// {dmemReq, pcStall, ifidStall, ifidFlush, idexStall, idexFlush, exmemStall, memwbBubble}.
module tb_pipeline_hazard_ctrl;
    localparam logic [7:0] CTL_NONE   = 8'b0000_0000;
    localparam logic [7:0] CTL_LOADU  = 8'b0110_0100;
    localparam logic [7:0] CTL_BRANCH = 8'b0001_0100;
    localparam logic [7:0] CTL_MSTALL = 8'b1110_1011;
    localparam logic [7:0] CTL_REQ    = 8'b1000_0000;
    localparam logic [7:0] CTL_RBR    = 8'b1001_0100;
    localparam logic [7:0] CTL_ABORT  = 8'b0000_0001;

    logic clk;
    logic rst;
    int   n_cmp;
    int   n_err;

    pipeline_hazard_if #(.CNT_W(32)) hz ();

    pipeline_hazard_ctrl #(.TIMEOUT(16), .CNT_W(32)) dut (
        .clk (clk),
        .rst (rst),
        .hz  (hz.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [7:0] ctl_vec();
        return {hz.dmemReq, hz.pcStall, hz.ifidStall, hz.ifidFlush,
                hz.idexStall, hz.idexFlush, hz.exmemStall, hz.memwbBubble};
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        hz.idRs1         = 5'd0;
        hz.idRs2         = 5'd0;
        hz.idUseRs1      = 1'b0;
        hz.idUseRs2      = 1'b0;
        hz.exMEMRead     = 1'b0;
        hz.exRegDes      = 5'd0;
        hz.exBranchTaken = 1'b0;
        hz.memMEMRead    = 1'b0;
        hz.memMEMWrite   = 1'b0;
        hz.dmemReady     = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        clear_inputs();
        tick();
        tick();
        rst = 1'b0;
        #1;
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        rst   = 1'b1;
        clear_inputs();
        tick();
        check("rst_ctl", {24'd0, ctl_vec()}, {24'd0, CTL_NONE});
        check("rst_stall_cnt", hz.stallCycles, 32'd0);
        check("rst_flush_cnt", hz.flushCount, 32'd0);
        check("rst_timeout", {31'd0, hz.memTimeout}, 32'd0);
        do_reset();

        // Load-use on rs2: exactly one stall cycle
        hz.exMEMRead = 1'b1; hz.exRegDes = 5'd5;
        hz.idRs2 = 5'd5; hz.idUseRs2 = 1'b1; hz.idRs1 = 5'd3; hz.idUseRs1 = 1'b1;
        #1;
        check("lu_rs2_ctl", {24'd0, ctl_vec()}, {24'd0, CTL_LOADU});
        tick();
        hz.exMEMRead = 1'b0;
        #1;
        check("lu_rs2_release", {24'd0, ctl_vec()}, {24'd0, CTL_NONE});
        check("lu_rs2_stall_cnt", hz.stallCycles, 32'd1);
        check("lu_rs2_flush_cnt", hz.flushCount, 32'd0);

        // x0 destination never stalls
        hz.exMEMRead = 1'b1; hz.exRegDes = 5'd0; hz.idRs2 = 5'd0; hz.idUseRs2 = 1'b1;
        #1;
        check("lu_x0_ctl", {24'd0, ctl_vec()}, {24'd0, CTL_NONE});

        // rs1 match only counts when rs1 is actually read
        hz.exRegDes = 5'd7; hz.idRs1 = 5'd7; hz.idUseRs1 = 1'b0; hz.idRs2 = 5'd9;
        #1;
        check("lu_rs1_unused", {24'd0, ctl_vec()}, {24'd0, CTL_NONE});
        hz.idUseRs1 = 1'b1;
        #1;
        check("lu_rs1_used", {24'd0, ctl_vec()}, {24'd0, CTL_LOADU});
        clear_inputs();

        // Branch beats load-use
        do_reset();
        hz.exMEMRead = 1'b1; hz.exRegDes = 5'd5; hz.idRs2 = 5'd5; hz.idUseRs2 = 1'b1;
        hz.exBranchTaken = 1'b1;
        #1;
        check("br_lu_ctl", {24'd0, ctl_vec()}, {24'd0, CTL_BRANCH});
        tick();
        clear_inputs();
        #1;
        check("br_flush_cnt", hz.flushCount, 32'd1);
        check("br_stall_cnt", hz.stallCycles, 32'd0);

        // Memory read ready after 3 cycles; branch held to prove suppression
        do_reset();
        hz.memMEMRead = 1'b1; hz.exBranchTaken = 1'b1;
        for (int c = 0; c < 4; c++) begin
            hz.dmemReady = (c == 3);
            #1;
            check($sformatf("mem3_ctl_c%0d", c), {24'd0, ctl_vec()},
                  {24'd0, (c == 3) ? CTL_RBR : CTL_MSTALL});
            tick();
        end
        clear_inputs();
        #1;
        check("mem3_after_ctl", {24'd0, ctl_vec()}, {24'd0, CTL_NONE});
        check("mem3_stall_cnt", hz.stallCycles, 32'd3);
        check("mem3_flush_cnt", hz.flushCount, 32'd1);

        // Timeout: 16 stalled cycles then one ABORT cycle
        do_reset();
        hz.memMEMWrite = 1'b1;
        for (int c = 0; c < 16; c++) begin
            #1;
            check($sformatf("to_stall_c%0d", c), {24'd0, ctl_vec()}, {24'd0, CTL_MSTALL});
            tick();
        end
        check("to_abort_ctl", {24'd0, ctl_vec()}, {24'd0, CTL_ABORT});
        check("to_flag_before", {31'd0, hz.memTimeout}, 32'd0);
        tick();
        check("to_flag_set", {31'd0, hz.memTimeout}, 32'd1);
        check("to_stall_cnt", hz.stallCycles, 32'd16);
        check("to_next_stall", {24'd0, ctl_vec()}, {24'd0, CTL_MSTALL});
        tick();
        hz.dmemReady = 1'b1;
        #1;
        check("to_next_ready", {24'd0, ctl_vec()}, {24'd0, CTL_REQ});
        tick();
        clear_inputs();
        #1;
        check("to_flag_sticky", {31'd0, hz.memTimeout}, 32'd1);
        check("to_stall_cnt2", hz.stallCycles, 32'd17);

        // Reset in the second WAIT cycle abandons the access at once
        do_reset();
        hz.memMEMRead = 1'b1;
        tick();
        tick();
        check("rw_pre_ctl", {24'd0, ctl_vec()}, {24'd0, CTL_MSTALL});
        rst = 1'b1;
        #1;
        check("rw_rst_ctl", {24'd0, ctl_vec()}, {24'd0, CTL_NONE});
        check("rw_rst_stall_cnt", hz.stallCycles, 32'd0);
        tick();
        rst = 1'b0;
        for (int c = 0; c < 16; c++) begin
            #1;
            check($sformatf("rw_stall_c%0d", c), {24'd0, ctl_vec()}, {24'd0, CTL_MSTALL});
            tick();
        end
        check("rw_abort_ctl", {24'd0, ctl_vec()}, {24'd0, CTL_ABORT});
        clear_inputs();
        tick();
        check("rw_stall_cnt", hz.stallCycles, 32'd16);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
